// File: rtl/branch_predict_resolve.sv
// Decode-stage branch resolver with a direct-mapped 2-bit saturating predictor table
// and saturating branch/mispredict statistics for the debug bus.
module branch_predict_resolve #(
    parameter int unsigned PC_WIDTH   = 16,
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned STAT_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    output logic                  predict_taken,
    input  logic                  resolve_valid,
    input  logic                  stall,
    input  logic [PC_WIDTH-1:0]   resolve_pc,
    input  logic [7:0]            operation,
    input  logic [2:0]            flags,
    input  logic                  predicted_taken,
    output logic                  take_branch_target,
    output logic                  mispredict,
    input  logic                  clear_stats,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);

    localparam int unsigned DEPTH     = 1 << INDEX_BITS;
    localparam logic [1:0]  CNT_RESET = 2'b01;
    localparam logic [1:0]  CNT_MAX   = 2'b11;
    localparam logic [1:0]  CNT_MIN   = 2'b00;
    localparam logic [4:0]  BR_CLASS  = 5'b00111;

    localparam logic [1:0]  SRC_ALWAYS = 2'b00;
    localparam logic [1:0]  SRC_CARRY  = 2'b01;
    localparam logic [1:0]  SRC_ZERO   = 2'b10;
    localparam logic [1:0]  SRC_NEG    = 2'b11;

    logic [1:0]            table_q [DEPTH];
    logic [STAT_WIDTH-1:0] branch_q;
    logic [STAT_WIDTH-1:0] mispredict_q;

    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] resolve_idx;
    logic                  is_branch;
    logic                  outcome;
    logic                  train;
    logic [1:0]            cnt_cur;
    logic [1:0]            cnt_next;

    // Only the low PC bits index the table; the rest are deliberately ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS], resolve_pc[PC_WIDTH-1:INDEX_BITS]};

    assign fetch_idx   = fetch_pc[INDEX_BITS-1:0];
    assign resolve_idx = resolve_pc[INDEX_BITS-1:0];

    // Fetch-side prediction reads pre-update state (no bypass from training).
    assign predict_taken = table_q[fetch_idx][1];

    // Branch condition evaluation against the ALU flags.
    always_comb begin
        outcome = 1'b0;
        case (operation[1:0])
            SRC_ALWAYS: outcome = 1'b1;
            SRC_CARRY:  outcome = (flags[2] == operation[2]);
            SRC_ZERO:   outcome = (flags[0] == operation[2]);
            SRC_NEG:    outcome = (flags[1] == operation[2]);
            default:    outcome = 1'b0;
        endcase
    end

    assign is_branch          = (operation[7:3] == BR_CLASS);
    assign take_branch_target = is_branch & outcome;
    assign train              = resolve_valid & ~stall & is_branch;
    assign mispredict         = train & (take_branch_target != predicted_taken);

    // Saturating counter step toward the resolved outcome.
    always_comb begin
        cnt_cur  = table_q[resolve_idx];
        cnt_next = cnt_cur;
        if (take_branch_target) begin
            if (cnt_cur != CNT_MAX) cnt_next = cnt_cur + 2'd1;
        end else begin
            if (cnt_cur != CNT_MIN) cnt_next = cnt_cur - 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                table_q[i] <= CNT_RESET;
            end
        end else if (train) begin
            table_q[resolve_idx] <= cnt_next;
        end
    end

    // Statistics; clear wins over a same-cycle increment, both hold at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            branch_q     <= '0;
            mispredict_q <= '0;
        end else if (clear_stats) begin
            branch_q     <= '0;
            mispredict_q <= '0;
        end else if (train) begin
            if (branch_q != '1) branch_q <= branch_q + STAT_WIDTH'(1);
            if (mispredict && (mispredict_q != '1)) mispredict_q <= mispredict_q + STAT_WIDTH'(1);
        end
    end

    assign branch_count     = branch_q;
    assign mispredict_count = mispredict_q;

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Scoreboard bench for branch_predict_resolve: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_branch_predict_resolve;

    localparam int unsigned PC_WIDTH   = 16;
    localparam int unsigned INDEX_BITS = 4;
    localparam int unsigned STAT_WIDTH = 4;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic                  predict_taken;
    logic                  resolve_valid;
    logic                  stall;
    logic [PC_WIDTH-1:0]   resolve_pc;
    logic [7:0]            operation;
    logic [2:0]            flags;
    logic                  predicted_taken;
    logic                  take_branch_target;
    logic                  mispredict;
    logic                  clear_stats;
    logic [STAT_WIDTH-1:0] branch_count;
    logic [STAT_WIDTH-1:0] mispredict_count;

    branch_predict_resolve #(
        .PC_WIDTH(PC_WIDTH), .INDEX_BITS(INDEX_BITS), .STAT_WIDTH(STAT_WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .predict_taken(predict_taken),
        .resolve_valid(resolve_valid), .stall(stall), .resolve_pc(resolve_pc),
        .operation(operation), .flags(flags), .predicted_taken(predicted_taken),
        .take_branch_target(take_branch_target), .mispredict(mispredict),
        .clear_stats(clear_stats), .branch_count(branch_count),
        .mispredict_count(mispredict_count)
    );

    always #5 clock = ~clock;

    // mask bits: [0] predict_taken, [1] take_branch_target, [2] mispredict, [3] counts
    typedef struct {
        string    name;
        logic [3:0] mask;
        logic     pt;
        logic     tbt;
        logic     mp;
        logic [3:0] bc;
        logic [3:0] mc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always @(negedge clock) begin
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.mask[0]) begin
                checks++;
                if (predict_taken !== e.pt) begin
                    errors++;
                    $display("FAIL %s predict_taken got %0b exp %0b", e.name, predict_taken, e.pt);
                end
            end
            if (e.mask[1]) begin
                checks++;
                if (take_branch_target !== e.tbt) begin
                    errors++;
                    $display("FAIL %s take_branch_target got %0b exp %0b", e.name, take_branch_target, e.tbt);
                end
            end
            if (e.mask[2]) begin
                checks++;
                if (mispredict !== e.mp) begin
                    errors++;
                    $display("FAIL %s mispredict got %0b exp %0b", e.name, mispredict, e.mp);
                end
            end
            if (e.mask[3]) begin
                checks++;
                if (branch_count !== e.bc || mispredict_count !== e.mc) begin
                    errors++;
                    $display("FAIL %s counts got %0d/%0d exp %0d/%0d", e.name,
                             branch_count, mispredict_count, e.bc, e.mc);
                end
            end
        end
    end

    task automatic expect_out(input string n, input logic [3:0] m, input logic pt, input logic tbt,
                              input logic mp, input logic [3:0] bc, input logic [3:0] mc);
        exp_t e;
        e.name = n; e.mask = m; e.pt = pt; e.tbt = tbt; e.mp = mp; e.bc = bc; e.mc = mc;
        sb_q.push_back(e);
    endtask

    task automatic drive(input logic [15:0] f, input logic rv, input logic st, input logic [15:0] rpc,
                         input logic [7:0] op, input logic [2:0] fl, input logic pin, input logic clr);
        fetch_pc = f; resolve_valid = rv; stall = st; resolve_pc = rpc;
        operation = op; flags = fl; predicted_taken = pin; clear_stats = clr;
    endtask

    task automatic idle(input logic [15:0] f);
        drive(f, 1'b0, 1'b0, 16'h0000, 8'h00, 3'b000, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle(16'h0000);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        // reset state across every table entry
        for (int i = 0; i < 16; i++) begin
            idle(16'(i));
            expect_out("reset_scan", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
            tick();
        end

        // first taken train at index 5 with a not-taken prediction
        drive(16'h0005, 1'b1, 1'b0, 16'h0025, 8'h3E, 3'b001, 1'b0, 1'b0);
        expect_out("first_train", 4'b1111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        tick();
        idle(16'h0005);
        expect_out("after_first", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);

        // three more taken trains: 10->11->11->11
        drive(16'h0005, 1'b1, 1'b0, 16'h0025, 8'h3E, 3'b001, 1'b1, 1'b0);
        expect_out("taken_a", 4'b1111, 1'b1, 1'b1, 1'b0, 4'd1, 4'd1);
        tick();
        expect_out("taken_b", 4'b1111, 1'b1, 1'b1, 1'b0, 4'd2, 4'd1);
        tick();
        expect_out("taken_c", 4'b1111, 1'b1, 1'b1, 1'b0, 4'd3, 4'd1);
        tick();
        // two not-taken trains: 11->10->01
        drive(16'h0005, 1'b1, 1'b0, 16'h0025, 8'h3D, 3'b000, 1'b1, 1'b0);
        expect_out("nt_d", 4'b1111, 1'b1, 1'b0, 1'b1, 4'd4, 4'd1);
        tick();
        expect_out("nt_e", 4'b1111, 1'b1, 1'b0, 1'b1, 4'd5, 4'd2);
        tick();
        idle(16'h0005);
        expect_out("after_nt", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd6, 4'd3);
        tick();

        // non-branch opcode never resolves taken or trains
        drive(16'h0005, 1'b1, 1'b0, 16'h0005, 8'h20, 3'b111, 1'b1, 1'b0);
        expect_out("nonbranch", 4'b1111, 1'b0, 1'b0, 1'b0, 4'd6, 4'd3);
        tick();
        // outcome is visible without resolve_valid, but no mispredict
        drive(16'h0005, 1'b0, 1'b0, 16'h0005, 8'h3F, 3'b010, 1'b0, 1'b0);
        expect_out("neg_pol1_novalid", 4'b1111, 1'b0, 1'b1, 1'b0, 4'd6, 4'd3);
        tick();
        drive(16'h0005, 1'b0, 1'b0, 16'h0005, 8'h3B, 3'b000, 1'b0, 1'b0);
        expect_out("neg_pol0_novalid", 4'b0110, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        tick();

        // stall suppresses training, stats and mispredict
        drive(16'h0005, 1'b1, 1'b1, 16'h0005, 8'h38, 3'b000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            expect_out("stalled", 4'b1111, 1'b0, 1'b1, 1'b0, 4'd6, 4'd3);
            tick();
        end
        idle(16'h0005);
        expect_out("after_stall", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd6, 4'd3);
        tick();

        // same-index fetch and resolve: read-before-write
        drive(16'h0003, 1'b1, 1'b0, 16'h0003, 8'h38, 3'b000, 1'b0, 1'b0);
        expect_out("rbw_same", 4'b1111, 1'b0, 1'b1, 1'b1, 4'd6, 4'd3);
        tick();
        idle(16'h0003);
        expect_out("rbw_next", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd7, 4'd4);
        tick();

        // saturation: 20 mispredicting trains at index 7
        for (int i = 0; i < 20; i++) begin
            drive(16'h0000, 1'b1, 1'b0, 16'h0007, 8'h38, 3'b000, 1'b0, 1'b0);
            expect_out("sat_loop", 4'b1110, 1'b0, 1'b1, 1'b1,
                       (7 + i > 15) ? 4'd15 : 4'(7 + i), (4 + i > 15) ? 4'd15 : 4'(4 + i));
            tick();
        end
        idle(16'h0007);
        expect_out("saturated", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd15, 4'd15);
        tick();

        // clear beats a simultaneous train; the table still trains
        drive(16'h0009, 1'b1, 1'b0, 16'h0009, 8'h38, 3'b000, 1'b0, 1'b1);
        expect_out("clear_cycle", 4'b1111, 1'b0, 1'b1, 1'b1, 4'd15, 4'd15);
        tick();
        idle(16'h0007);
        expect_out("after_clear", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        idle(16'h0009);
        expect_out("clear_trained_tbl", 4'b1001, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();

        // asynchronous reset mid-training
        drive(16'h0009, 1'b1, 1'b0, 16'h0009, 8'h38, 3'b000, 1'b0, 1'b0);
        #2 reset = 1'b1;
        expect_out("async_reset", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        reset = 1'b0;
        idle(16'h0009);
        expect_out("post_reset_9", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();
        idle(16'h0007);
        expect_out("post_reset_7", 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        tick();

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clock);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain scoreboard left %0d exp 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Parametrised successor to the decode-stage branch resolver. Resolves branch-class instructions against the ALU flags and also keeps a direct-mapped table of 2-bit saturating counters. Fetch reads a taken/not-taken prediction from this table. Decode resolves the real outcome, flags a mispredict when the two differ, and trains the table. Saturating branch and mispredict statistics counters are exported for the debug bus.

## Interface
Parameters:
- PC_WIDTH, 16, width of program-counter values
- INDEX_BITS, 4, table index width; depth = 2^INDEX_BITS entries, index = pc[INDEX_BITS-1:0]
- STAT_WIDTH, 16, width of each statistics counter

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-high
- fetch_pc  in  PC_WIDTH  PC of the instruction being fetched
- predict_taken  out  1  combinational; MSB of counter[fetch_pc index]
- resolve_valid  in  1  decode holds a valid instruction this cycle
- stall  in  1  decode stalled; suppresses training and statistics
- resolve_pc  in  PC_WIDTH  PC of the instruction in decode
- operation  in  8  opcode of the instruction in decode
- flags  in  3  {negative? no: [2]=carry, [1]=negative, [0]=zero}
- predicted_taken  in  1  predict_taken value carried down from fetch with this instruction
- take_branch_target  out  1  combinational resolved outcome
- mispredict  out  1  combinational; redirect/flush request
- clear_stats  in  1  synchronous clear of both statistics counters
- branch_count  out  STAT_WIDTH  resolved branches, saturating
- mispredict_count  out  STAT_WIDTH  mispredicts, saturating

## Operation
- is_branch = (operation[7:3] == 5'b00111).
- Condition source is selected by operation[1:0]:
  - 00: unconditional, outcome 1
  - 01: carry, flags[2]
  - 10: zero, flags[0]
  - 11: negative, flags[1]
- For conditional branches, outcome = (selected flag == operation[2]).
- take_branch_target = is_branch & outcome. It is 0 for every non-branch opcode, independent of resolve_valid.
- train = resolve_valid & ~stall & is_branch.
- mispredict = train & (take_branch_target != predicted_taken). It is 0 while stalled.
- Counter states:
  - 00: strong not-taken
  - 01: weak not-taken
  - 10: weak taken
  - 11: strong taken
- On train, counter[resolve_pc index] increments if taken and decrements if not taken. It saturates at 11 and 00; no wrap.
- Unconditional branches train toward taken like any other branch.
- Statistics, on train:
  - branch_count += 1
  - mispredict_count += 1 when mispredict
  - Both hold at all-ones; no wrap.
- clear_stats sets both statistics counters to 0 at the edge and has priority over a same-cycle increment. The table is untouched.
- Non-branch opcodes never modify any state.

## Timing
- Reset, asynchronous, takes effect immediately:
  - every counter = 01
  - branch_count = mispredict_count = 0
  - so predict_taken = 0
- predict_taken, take_branch_target and mispredict are combinational, with zero latency. All state updates on the rising clock edge after train.
- When fetch and resolve hit the same index in the same cycle, predict_taken shows the pre-update value. The new value is visible the following cycle (read-before-write, no bypass).
- Back-to-back trains of the same index on consecutive cycles each apply one step.
- reset asserted mid-training overrides the pending edge update. When reset deasserts, state is exactly the reset state.
- stall held for N cycles with resolve_valid high produces no training, no statistics change, and no mispredict.

## Test plan
- Reset, fetch_pc = 0x0000..0x000F: predict_taken = 0 everywhere; branch_count = 0; mispredict_count = 0.
- operation = 0x3E (zero, polarity 1), flags = 3'b001, predicted_taken = 0, resolve_pc = 0x0025, resolve_valid = 1:
  - take_branch_target = 1 and mispredict = 1 in the same cycle
  - after the edge, predict_taken at fetch_pc = 0x0005 is 1
  - branch_count = 1 and mispredict_count = 1
- Three more taken trains at index 5, then two not-taken (operation = 0x3D, carry polarity 1, flags = 3'b000):
  - counter path 10→11→11→11→10→01
  - predict_taken ends at 0
- operation = 0x20 with resolve_valid = 1 and any flags: take_branch_target = 0, mispredict = 0, no state change. Also, a branch with stall = 1: mispredict = 0, counts unchanged.
- Same-cycle fetch_pc = resolve_pc = 0x0003, counter at 01, taken train: predict_taken = 0 this cycle and 1 the next.
- Statistics saturation and clear:
  - with STAT_WIDTH = 4, 20 mispredicting trains → both counts = 15
  - clear_stats with a simultaneous train → both counts = 0
  - assert reset mid-sequence → table and counts return to reset values asynchronously
